// File: rtl/diff_exec_ctrl.sv
// Sequencer for "diff rd, rs, rt": reads both operands through one synchronous
// register-file port, feeds the first-difference unit, and writes the result back to rd.
module diff_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    input  logic [REG_AW-1:0] rd_idx,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] diff_in1,
    output logic [DATA_W-1:0] diff_in2,
    input  logic [DATA_W-1:0] diff_out,
    input  logic              diff_ifequal,
    output logic              eq_flag
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] RD_B  = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] EVAL  = 3'd4;
    localparam logic [2:0] WB    = 3'd5;

    localparam logic [DATA_W-1:0] ALL_EQUAL = DATA_W'(32);

    logic [2:0]        state_reg, state_next;
    logic [REG_AW-1:0] rs_reg, rt_reg, rd_reg;
    logic [DATA_W-1:0] op_a_reg, op_b_reg, res_reg;
    logic              eq_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RD_A;
            RD_A:    state_next = RD_B;
            RD_B:    state_next = LATCH;
            LATCH:   state_next = EVAL;
            EVAL:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so each operand is captured
    // in the state after its address was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            eq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                rs_reg <= rs_idx;
                rt_reg <= rt_idx;
                rd_reg <= rd_idx;
            end
            if (state_reg == RD_B)  op_a_reg <= rf_rdata;
            if (state_reg == LATCH) op_b_reg <= rf_rdata;
            if (state_reg == EVAL) begin
                res_reg <= diff_ifequal ? ALL_EQUAL : diff_out;
                eq_reg  <= diff_ifequal;
            end
        end
    end

    always_comb begin
        rf_raddr = '0;
        case (state_reg)
            RD_A:        rf_raddr = rs_reg;
            RD_B, LATCH: rf_raddr = rt_reg;
            default:     rf_raddr = '0;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == WB);
    assign rf_we    = (state_reg == WB);
    assign rf_waddr = (state_reg == WB) ? rd_reg  : '0;
    assign rf_wdata = (state_reg == WB) ? res_reg : '0;
    assign diff_in1 = op_a_reg;
    assign diff_in2 = op_b_reg;
    assign eq_flag  = eq_reg;

endmodule

// File: tb/tb_diff_exec_ctrl.sv
// Bench for diff_exec_ctrl: register file and first-difference unit are modelled
// here; results are predicted from operand values with a trailing-zero calculation.
module tb_diff_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic        busy, done, rf_we, eq_flag, diff_ifequal;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, diff_in1, diff_in2, diff_out;

    int vectors = 0;
    int errors  = 0;
    int wb_count = 0;

    logic [31:0] regs [32];
    logic [31:0] exp_regs [32];
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    diff_exec_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .diff_in1(diff_in1), .diff_in2(diff_in2),
        .diff_out(diff_out), .diff_ifequal(diff_ifequal),
        .eq_flag(eq_flag)
    );

    // Synchronous-read register file with a bench-side preload port.
    always @(posedge clk) begin
        rf_rdata <= regs[rf_raddr];
        if (rf_we) regs[rf_waddr] <= rf_wdata;
        else if (pl_we) regs[pl_addr] <= pl_data;
        if (rf_we) wb_count <= wb_count + 1;
    end

    // First-difference unit; diff_out is deliberately junk when operands match.
    always_comb begin
        diff_ifequal = (diff_in1 == diff_in2);
        diff_out = 32'd7;
        for (int i = 31; i >= 0; i--)
            if (diff_in1[i] != diff_in2[i]) diff_out = 32'(i);
    end

    function automatic logic [31:0] ref_diff(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        if (x == 32'd0) return 32'd32;
        return 32'($clog2(x & (~x + 32'd1)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a[4:0]; pl_data = d;
        exp_regs[a] = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Called one step after a rising edge with the DUT idle; returns the same way.
    task automatic run_op(input int rs, input int rt, input int rd, input string tag);
        logic [31:0] exp_res;
        logic        exp_eq;
        exp_res = ref_diff(exp_regs[rs], exp_regs[rt]);
        exp_eq  = (exp_regs[rs] == exp_regs[rt]);
        start = 1'b1; rs_idx = rs[4:0]; rt_idx = rt[4:0]; rd_idx = rd[4:0];
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rf_raddr !== 5'd0) begin
            errors++;
            $display("FAIL %s idle busy=%0b raddr=%0d want busy=0 raddr=0", tag, busy, rf_raddr);
        end
        tick();
        start = 1'b0;
        rs_idx = 5'($urandom); rt_idx = 5'($urandom); rd_idx = 5'($urandom);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || done !== (k == 5) || rf_we !== (k == 5)) begin
                errors++;
                $display("FAIL %s cycle%0d busy=%0b done=%0b we=%0b want 1/%0b/%0b",
                         tag, k, busy, done, rf_we, k == 5, k == 5);
            end
            if (k == 1 && rf_raddr !== rs[4:0]) begin
                errors++;
                $display("FAIL %s raddr_a got %0d want %0d", tag, rf_raddr, rs);
            end
            if ((k == 2 || k == 3) && rf_raddr !== rt[4:0]) begin
                errors++;
                $display("FAIL %s raddr_b got %0d want %0d", tag, rf_raddr, rt);
            end
            if (k == 5) begin
                vectors++;
                if (rf_waddr !== rd[4:0] || rf_wdata !== exp_res) begin
                    errors++;
                    $display("FAIL %s wb waddr=%0d wdata=%0d want %0d/%0d",
                             tag, rf_waddr, rf_wdata, rd, exp_res);
                end
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || eq_flag !== exp_eq || regs[rd] !== exp_res) begin
            errors++;
            $display("FAIL %s after busy=%0b done=%0b eq=%0b r%0d=%0d want 0/0/%0b/%0d",
                     tag, busy, done, eq_flag, rd, regs[rd], exp_eq, exp_res);
        end
        exp_regs[rd] = exp_res;
        $display("op %s: r%0d=%08h r%0d=%08h -> r%0d=%0d eq=%0b",
                 tag, rs, diff_in1, rt, diff_in2, rd, regs[rd], eq_flag);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({busy, done, rf_we, eq_flag} !== 4'b0 || rf_raddr !== 5'd0 || rf_waddr !== 5'd0 ||
            rf_wdata !== 32'd0 || diff_in1 !== 32'd0 || diff_in2 !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs busy=%0b done=%0b we=%0b eq=%0b ra=%0d wa=%0d wd=%0h in1=%0h in2=%0h want all 0",
                     tag, busy, done, rf_we, eq_flag, rf_raddr, rf_waddr, rf_wdata, diff_in1, diff_in2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pl_we = 1'b0;
        rs_idx = '0; rt_idx = '0; rd_idx = '0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) set_reg(i, $urandom);
        $display("reset: outputs checked, register file preloaded");
    endtask

    task automatic test_directed();
        set_reg(1, 32'h0000_0010); set_reg(2, 32'h0);
        run_op(1, 2, 3, "bit4");
        set_reg(4, 32'hDEAD_BEEF); set_reg(5, 32'hDEAD_BEEF);
        run_op(4, 5, 6, "equal");
        run_op(7, 7, 8, "same_reg");
        set_reg(1, 32'h8000_0001);
        run_op(1, 2, 9, "bit0");
        set_reg(1, 32'h8000_0000);
        run_op(1, 2, 10, "bit31");
        run_op(2, 1, 0, "reg0_dest");
    endtask

    task automatic test_rd_alias();
        set_reg(5, 32'h0000_00F0); set_reg(6, 32'h0000_000F);
        run_op(5, 6, 5, "rd_eq_rs");
        run_op(5, 6, 7, "reread_r5");
        run_op(6, 5, 6, "rd_eq_rt");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            int rs, rt, rd;
            rs = $urandom_range(31); rt = $urandom_range(31); rd = $urandom_range(31);
            if ($urandom_range(3) == 0) set_reg(rt, exp_regs[rs]);
            else if ($urandom_range(1) == 0) set_reg(rs, exp_regs[rt] ^ (32'd1 << $urandom_range(31)));
            run_op(rs, rt, rd, "random");
        end
    endtask

    task automatic test_back_to_back();
        int wb_start;
        logic [4:0]  rd0, rd1;
        logic [31:0] res0, res1;
        wb_start = wb_count;
        rd0 = '0; rd1 = '0; res0 = '0; res1 = '0;
        for (int c = 0; c < 14; c++) begin
            start = (c < 12);
            rs_idx = 5'($urandom); rt_idx = 5'($urandom); rd_idx = 5'($urandom);
            if (c == 0 || c == 6) begin
                logic [31:0] r;
                r = ref_diff(exp_regs[rs_idx], exp_regs[rt_idx]);
                exp_regs[rd_idx] = r;
                if (c == 0) begin rd0 = rd_idx; res0 = r; end
                else        begin rd1 = rd_idx; res1 = r; end
            end
            @(negedge clk);
            vectors++;
            if (done !== (c == 5 || c == 11) || busy !== !(c == 0 || c == 6 || c >= 12)) begin
                errors++;
                $display("FAIL b2b cycle%0d done=%0b busy=%0b want %0b/%0b",
                         c, done, busy, c == 5 || c == 11, !(c == 0 || c == 6 || c >= 12));
            end
            if ((c == 5 && (rf_waddr !== rd0 || rf_wdata !== res0)) ||
                (c == 11 && (rf_waddr !== rd1 || rf_wdata !== res1))) begin
                errors++;
                $display("FAIL b2b wb cycle%0d waddr=%0d wdata=%0d want %0d/%0d",
                         c, rf_waddr, rf_wdata, c == 5 ? rd0 : rd1, c == 5 ? res0 : res1);
            end
            tick();
        end
        vectors++;
        if (wb_count - wb_start != 2) begin
            errors++;
            $display("FAIL b2b writebacks got %0d want 2", wb_count - wb_start);
        end
        $display("b2b: r%0d=%0d r%0d=%0d writebacks=%0d", rd0, regs[rd0], rd1, regs[rd1], wb_count - wb_start);
    endtask

    task automatic test_reset_mid();
        int wb_start;
        logic [31:0] old_rd;
        set_reg(11, 32'h0000_0100); set_reg(12, 32'h0);
        set_reg(13, 32'h1234_5678);
        old_rd = exp_regs[13];
        wb_start = wb_count;
        start = 1'b1; rs_idx = 5'd11; rt_idx = 5'd12; rd_idx = 5'd13;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        @(posedge clk); #1;
        check_all_zero("reset_mid_held");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (wb_count != wb_start || regs[13] !== old_rd || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort writes=%0d r13=%08h busy=%0b want 0/%08h/0",
                     wb_count - wb_start, regs[13], busy, old_rd);
        end
        $display("reset_mid: op aborted, r13=%08h", regs[13]);
        run_op(11, 12, 13, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rd_alias();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/diff_exec_ctrl.md
# diff_exec_ctrl

Multi-cycle sequencer that executes the `diff rd, rs, rt` instruction around the combinational first-difference unit. It reads both source operands from the register file through a single synchronous read port and drives them into the diff unit. It then captures the diff result, with the all-equal case mapped to 32, and writes it back to `rd`. It sits between the decode/control stage (start handshake) and the register file writeback port.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width. The diff unit is fixed at 32.
- `REG_AW`, 5, register index width (32 registers).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to execute one diff. Sampled only in IDLE.
- `rs_idx`  in  REG_AW  first source register index, latched on accept.
- `rt_idx`  in  REG_AW  second source register index, latched on accept.
- `rd_idx`  in  REG_AW  destination register index, latched on accept.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse, coincident with the writeback.
- `rf_raddr`  out  REG_AW  register-file read address.
- `rf_rdata`  in  DATA_W  register-file read data, valid the cycle after `rf_raddr`.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  REG_AW  write address.
- `rf_wdata`  out  DATA_W  write data.
- `diff_in1`  out  DATA_W  operand A to the diff unit.
- `diff_in2`  out  DATA_W  operand B to the diff unit.
- `diff_out`  in  DATA_W  index of the lowest differing bit (0..31).
- `diff_ifequal`  in  1  high when the operands are identical. `diff_out` is don't-care in that case.
- `eq_flag`  out  1  registered copy of `diff_ifequal` from the last completed op.

## Operation
State machine (registered state): IDLE -> RD_A -> RD_B -> LATCH -> EVAL -> WB -> IDLE.
- **IDLE:** `rf_raddr`=0.
  - If `start`=1, latch rs/rt/rd into internal registers and go to RD_A.
  - Otherwise stay in IDLE.
- **RD_A:** `rf_raddr`=rs.
- **RD_B:** `rf_raddr`=rt; op_a <= `rf_rdata`.
- **LATCH:** `rf_raddr`=rt (held); op_b <= `rf_rdata`.
- **EVAL:**
  - `diff_in1`/`diff_in2` are driven from op_a/op_b continuously in all states.
  - res <= `diff_ifequal` ? 32 : `diff_out`.
  - `eq_flag` <= `diff_ifequal`.
- **WB:** `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=res, `done`=1. Unconditionally returns to IDLE.
- Result width rules:
  - Result is zero-extended to DATA_W.
  - The valid range is 0..32; 32 is the all-equal code.
  - No special handling for register 0.
- `rf_we`, `done` and `busy` decode from the registered state only (glitch-free, no input paths).
- Operand hazards:
  - rd equal to rs or rt is legal; both reads complete before the write.
  - rs == rt always yields 32.

## Timing
- `start` sampled high in IDLE at edge T:
  - RD_A at T+1.
  - `done`/`rf_we` high for exactly the cycle T+5 to T+6.
  - `busy` high from T+1 through T+6 (the end of WB); low from T+6.
- Latency: 5 cycles start-to-writeback. Throughput: one op per 6 cycles.
- The earliest next accept is the IDLE cycle after WB.
- `start` while busy (including during WB) is ignored and not queued. Indices are not re-latched.
- Reset values (rst_n=0, asynchronous):
  - state=IDLE.
  - `busy`=0, `done`=0, `rf_we`=0, `eq_flag`=0.
  - `rf_raddr`=0, `rf_waddr`=0, `rf_wdata`=0.
  - op_a=op_b=res=0, so `diff_in1`=`diff_in2`=0.
- Reset mid-operation: the op is aborted with no register-file write and no `done`. Operation resumes from IDLE after reset release.
- `start` held high continuously produces one op every 6 cycles.

## Test plan
- r1=0x0000_0010, r2=0x0000_0000, start(rs=1, rt=2, rd=3) -> `done` at T+5, r3=4, `eq_flag`=0, `busy` low at T+6.
- r4=r5=0xDEAD_BEEF, start(rs=4, rt=5, rd=6) -> r6=32, `eq_flag`=1. Also rs=rt=7 -> result 32.
- r1=0x8000_0001 vs r2=0 -> result 0 (lowest differing bit). r1=0x8000_0000 vs r2=0 -> result 31.
- `start` held high for 12 cycles -> exactly two writebacks at T+5 and T+11, with indices latched at each accept only.
- `rst_n` pulsed low while in EVAL -> no `rf_we`, all outputs 0 immediately. A following op completes correctly.
- rd==rs: r5=0xF0, r6=0x0F, start(rs=5, rt=6, rd=5) -> r5=0 after WB. A repeat op then reads the new r5.
